// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths for the instruction cache and future data cache
package icache_pkg;

  // Core-wide word and address widths.
  localparam int IC_ID_WIDTH      = 32;
  localparam int IC_ADDR_WIDTH    = 32;

  // Cache geometry: one 32-bit word per line, 2^IC_INDEX_WIDTH lines.
  localparam int IC_INDEX_WIDTH   = 8;
  localparam int IC_TAG_WIDTH     = IC_ADDR_WIDTH - IC_INDEX_WIDTH - 2;

  // Word-align a byte address by clearing the two byte-offset bits.
  function automatic logic [IC_ADDR_WIDTH-1:0] word_align(input logic [IC_ADDR_WIDTH-1:0] a);
    return {a[IC_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with single-word refill
module icache
  import icache_pkg::*;
#(
  parameter int IDWidth      = IC_ID_WIDTH,
  parameter int AddressWidth = IC_ADDR_WIDTH,
  parameter int IndexWidth   = IC_INDEX_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [AddressWidth-1:0] if_icache_inst_addr_in,
  output logic                    icache_if_miss_out,
  output logic [IDWidth-1:0]      icache_if_inst_out,
  output logic                    icache_memctrl_en_out,
  output logic [AddressWidth-1:0] icache_memctrl_addr_out,
  input  logic                    memctrl_icache_valid_in,
  input  logic [IDWidth-1:0]      memctrl_icache_inst_in
);

  localparam int TagWidth = AddressWidth - IndexWidth - 2;
  localparam int Lines    = 1 << IndexWidth;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    en_q, en_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    fill_we;

  logic [Lines-1:0]        valid_q;
  logic [TagWidth-1:0]     tag_q  [Lines];
  logic [IDWidth-1:0]      data_q [Lines];

  logic [IndexWidth-1:0]   look_idx;
  logic [TagWidth-1:0]     look_tag;
  logic [IndexWidth-1:0]   fill_idx;
  logic [TagWidth-1:0]     fill_tag;
  logic                    hit;

  // Byte offset of the fetch address plays no part in a word lookup.
  logic                    unused_addr_bits;
  assign unused_addr_bits = &{1'b0, if_icache_inst_addr_in[1:0]};

  assign look_idx = if_icache_inst_addr_in[IndexWidth+1:2];
  assign look_tag = if_icache_inst_addr_in[AddressWidth-1:IndexWidth+2];

  // Refills always land at the line named by the held request address,
  // not whatever IF happens to be fetching when the response returns.
  assign fill_idx = addr_q[IndexWidth+1:2];
  assign fill_tag = addr_q[AddressWidth-1:IndexWidth+2];

  // Zero-latency lookup; forced to miss while reset is asserted.
  always_comb begin
    hit                = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && rst_in;
    icache_if_miss_out = !hit;
    icache_if_inst_out = hit ? data_q[look_idx] : '0;
  end

  assign icache_memctrl_en_out   = en_q;
  assign icache_memctrl_addr_out = addr_q;

  // Next-state logic: issue a refill on an IDLE miss, install on the response.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    addr_d  = addr_q;
    fill_we = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (!hit) begin
            en_d    = 1'b1;
            addr_d  = word_align(if_icache_inst_addr_in);
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (memctrl_icache_valid_in) begin
            fill_we = 1'b1;
            en_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control registers and valid bits; reset abandons any outstanding refill.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: single write port, contents need no reset.
  always_ff @(posedge clk_in) begin
    if (rst_in && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= memctrl_icache_inst_in;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard testbench for icache with directed and random stimulus
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] fetch_addr;
  logic        miss;
  logic [31:0] inst;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_inst;

  icache dut (
    .clk_in                  (clk),
    .rst_in                  (rst_n),
    .rdy_in                  (rdy),
    .if_icache_inst_addr_in  (fetch_addr),
    .icache_if_miss_out      (miss),
    .icache_if_inst_out      (inst),
    .icache_memctrl_en_out   (mem_en),
    .icache_memctrl_addr_out (mem_addr),
    .memctrl_icache_valid_in (mem_valid),
    .memctrl_icache_inst_in  (mem_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [31:0] inst;
    logic        en;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: what the cache holds per line, and the single outstanding request.
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];
  bit          m_pend = 0;
  logic [31:0] m_req  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every cycle's outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("miss_out", {31'b0, miss}, {31'b0, e.miss});
      check("inst_out", inst, e.inst);
      check("en_out", {31'b0, mem_en}, {31'b0, e.en});
      check("addr_out", mem_addr, e.addr);
    end
  end

  // One clock of stimulus: drive inputs, predict outputs, advance the model.
  task automatic step(input logic [31:0] a, input logic r, input logic rs,
                      input logic v, input logic [31:0] d);
    int   idx;
    logic h;
    exp_t e;
    @(posedge clk);
    #1;
    fetch_addr = a;
    rdy        = r;
    rst_n      = rs;
    mem_valid  = v;
    mem_inst   = d;
    idx = int'(a[9:2]);
    h   = rs && m_valid[idx] && (m_tag[idx] == a[31:10]);
    e.miss = !h;
    e.inst = h ? m_data[idx] : 32'h0;
    e.en   = m_pend;
    e.addr = m_req;
    exp_q.push_back(e);
    if (!rs) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_pend = 0;
      m_req  = 32'h0;
    end else if (r) begin
      if (!m_pend) begin
        if (!h) begin
          m_pend = 1;
          m_req  = a & 32'hFFFF_FFFC;
        end
      end else if (v) begin
        m_valid[int'(m_req[9:2])] = 1;
        m_tag[int'(m_req[9:2])]   = m_req[31:10];
        m_data[int'(m_req[9:2])]  = d;
        m_pend = 0;
      end
    end
  endtask

  task automatic idle(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) step(a, 1, 1, 0, 32'h0);
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    step(a, 1, 1, 0, 32'h0);
    step(a, 1, 1, 0, 32'h0);
    step(a, 1, 1, 1, d);
    step(a, 1, 1, 0, 32'h0);
  endtask

  initial begin
    rst_n = 0; rdy = 1; fetch_addr = 0; mem_valid = 0; mem_inst = 0;
    step(32'h0, 1, 0, 0, 32'h0);
    step(32'h0, 1, 0, 0, 32'h0);

    // Cold miss with three waiting cycles, then install and hit.
    step(32'h0, 1, 1, 0, 32'h0);
    idle(32'h0, 3);
    step(32'h0, 1, 1, 1, 32'h0000_0093);
    idle(32'h0, 2);

    // Conflict on index 0.
    step(32'h0, 1, 0, 0, 32'h0);
    fill(32'h000, 32'h1111_1111);
    fill(32'h400, 32'h2222_2222);
    step(32'h000, 1, 1, 0, 32'h0);
    step(32'h400, 1, 1, 0, 32'h0);
    step(32'h400, 1, 1, 1, 32'h3333_3333);
    idle(32'h400, 1);

    // Redirect while waiting.
    step(32'h10, 1, 1, 0, 32'h0);
    step(32'h20, 1, 1, 0, 32'h0);
    step(32'h20, 1, 1, 0, 32'h0);
    step(32'h20, 1, 1, 1, 32'hAAAA_0010);
    step(32'h20, 1, 1, 0, 32'h0);
    step(32'h20, 1, 1, 1, 32'hAAAA_0020);
    idle(32'h10, 1);
    idle(32'h23, 1);

    // Stall during WAIT.
    step(32'h44, 1, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(32'h44, 0, 1, 0, 32'h0);
    step(32'h44, 0, 1, 1, 32'hBAD0_BAD0);
    step(32'h44, 1, 1, 1, 32'h0000_0044);
    idle(32'h44, 1);

    // Reset mid-fill, then a late response.
    step(32'h80, 1, 1, 0, 32'h0);
    step(32'h80, 1, 1, 0, 32'h0);
    step(32'h80, 1, 0, 0, 32'h0);
    step(32'h44, 1, 1, 1, 32'h5555_5555);
    idle(32'h80, 1);

    // Spurious response while idle: refill 0x44 first, then a stray pulse.
    step(32'h44, 1, 1, 1, 32'h0000_0044);
    step(32'h44, 1, 1, 1, 32'h0000_0044);
    step(32'h44, 1, 1, 1, 32'hDEAD_BEEF);
    idle(32'h44, 1);

    // Random traffic over a small address pool to force hits and conflicts.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic        r, rs, v;
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      r  = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 99) != 0);
      v  = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      step(a, r, rs, v, $urandom);
    end

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
